// File: rtl/fir4_coef_sched.sv
// rtl/fir4_coef_sched.sv - sample sequencer and shadow/active coefficient manager for a 4-tap FIR
// Optional bank readback port enabled by FIR4_COEF_SCHED_RDBK_EN.
module fir4_coef_sched #(
    parameter int W_IN      = 7,
    parameter int C_IN      = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic signed [W_IN-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   cfg_wr,
    input  logic [1:0]             cfg_addr,
    input  logic signed [C_IN-1:0] cfg_wdata,
    input  logic                   cfg_commit,
    output logic                   cfg_busy,
    output logic                   commit_done,
    output logic signed [W_IN-1:0] fir_x,
    output logic signed [C_IN-1:0] fir_c0,
    output logic signed [C_IN-1:0] fir_c1,
    output logic signed [C_IN-1:0] fir_c2,
    output logic signed [C_IN-1:0] fir_c3,
`ifdef FIR4_COEF_SCHED_RDBK_EN
    input  logic                   rd_sel,
    input  logic [1:0]             rd_addr,
    output logic signed [C_IN-1:0] rd_data,
`endif
    output logic                   y_valid
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);

    logic [1:0]             state;
    logic [1:0]             drain_cnt;
    logic signed [C_IN-1:0] shadow [4];
    logic signed [C_IN-1:0] active [4];
    logic                   accept;

    assign s_ready  = (state == ST_RUN);
    assign cfg_busy = (state != ST_RUN);
    assign accept   = s_valid && s_ready;
    // Idle cycles present zero to the FIR; it has no stall, so a bubble is a zero sample.
    assign fir_x    = accept ? s_data : '0;

    assign fir_c0 = active[0];
    assign fir_c1 = active[1];
    assign fir_c2 = active[2];
    assign fir_c3 = active[3];

`ifdef FIR4_COEF_SCHED_RDBK_EN
    assign rd_data = rd_sel ? active[rd_addr] : shadow[rd_addr];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_RUN;
            drain_cnt   <= 2'd0;
            y_valid     <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            y_valid     <= accept;
            commit_done <= (state == ST_SWAP);
            case (state)
                ST_RUN: begin
                    if (cfg_commit) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // The swap copies the shadow value held before this edge, so a same-cycle write lands in shadow only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (state == ST_SWAP) begin
                for (int i = 0; i < 4; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (cfg_wr) begin
                shadow[cfg_addr] <= cfg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_fir4_coef_sched.sv
// tb/tb_fir4_coef_sched.sv - randomized self-checking bench for fir4_coef_sched
// Build with FIR4_COEF_SCHED_RDBK_EN to also check the readback port.
module tb_fir4_coef_sched;

    localparam int W_IN = 7;
    localparam int C_IN = 5;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic signed [W_IN-1:0] s_data = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic                   cfg_wr = 1'b0;
    logic [1:0]             cfg_addr = '0;
    logic signed [C_IN-1:0] cfg_wdata = '0;
    logic                   cfg_commit = 1'b0;
    logic                   cfg_busy;
    logic                   commit_done;
    logic signed [W_IN-1:0] fir_x;
    logic signed [C_IN-1:0] fir_c0, fir_c1, fir_c2, fir_c3;
    logic                   y_valid;
`ifdef FIR4_COEF_SCHED_RDBK_EN
    logic                   rd_sel = 1'b0;
    logic [1:0]             rd_addr = '0;
    logic signed [C_IN-1:0] rd_data;
`endif

    always #5 clk = ~clk;

    fir4_coef_sched #(.W_IN(W_IN), .C_IN(C_IN), .DRAIN_CYC(3)) dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .commit_done(commit_done),
        .fir_x(fir_x), .fir_c0(fir_c0), .fir_c1(fir_c1), .fir_c2(fir_c2), .fir_c3(fir_c3),
`ifdef FIR4_COEF_SCHED_RDBK_EN
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
`endif
        .y_valid(y_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a commit blocks input for four cycles; the bank copy happens as that window closes.
    int m_sh [4];
    int m_ac [4];
    int m_left;
    int m_done;
    int m_yv;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i] <= 0;
                m_ac[i] <= 0;
            end
            m_left <= 0;
            m_done <= 0;
            m_yv   <= 0;
        end else begin
            m_yv   <= (s_valid && m_left == 0) ? 1 : 0;
            m_done <= (m_left == 1) ? 1 : 0;
            if (m_left == 1) begin
                for (int i = 0; i < 4; i++) m_ac[i] <= m_sh[i];
            end
            if (cfg_wr) m_sh[cfg_addr] <= int'(cfg_wdata);
            if (m_left == 0) begin
                if (cfg_commit) m_left <= 4;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("s_ready", int'(s_ready), (m_left == 0) ? 1 : 0);
        chk("cfg_busy", int'(cfg_busy), (m_left != 0) ? 1 : 0);
        chk("fir_x", int'(fir_x), (s_valid && m_left == 0) ? int'(s_data) : 0);
        chk("y_valid", int'(y_valid), m_yv);
        chk("commit_done", int'(commit_done), m_done);
        chk("fir_c0", int'(fir_c0), m_ac[0]);
        chk("fir_c1", int'(fir_c1), m_ac[1]);
        chk("fir_c2", int'(fir_c2), m_ac[2]);
        chk("fir_c3", int'(fir_c3), m_ac[3]);
`ifdef FIR4_COEF_SCHED_RDBK_EN
        chk("rd_data", int'(rd_data), rd_sel ? m_ac[rd_addr] : m_sh[rd_addr]);
`endif
    end

    task automatic drive(input bit v, input int d, input bit wr, input int a, input int wd, input bit com);
        s_valid    = v;
        s_data     = d[W_IN-1:0];
        cfg_wr     = wr;
        cfg_addr   = a[1:0];
        cfg_wdata  = wd[C_IN-1:0];
        cfg_commit = com;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_commit_end(input string name);
        int low;
        low = 0;
        for (int i = 0; i < 10 && !s_ready; i++) begin
            low++;
            idle();
        end
        chk({name, "_ready_low_cycles"}, low, 4);
        chk({name, "_done"}, int'(commit_done), 1);
    endtask

    initial begin
        int pulses;
        int v;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("lit_rst_ready", int'(s_ready), 1);
        chk("lit_rst_yvalid", int'(y_valid), 0);
        chk("lit_rst_c0", int'(fir_c0), 0);

        drive(1, 5, 0, 0, 0, 0);
        chk("lit_first_yvalid", int'(y_valid), 1);

        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 2, 0);
        drive(0, 0, 1, 2, 3, 0);
        drive(0, 0, 1, 3, 4, 0);
        drive(1, 3, 0, 0, 0, 1);
        wait_commit_end("lit_commit1");
        chk("lit_c0", int'(fir_c0), 1);
        chk("lit_c1", int'(fir_c1), 2);
        chk("lit_c2", int'(fir_c2), 3);
        chk("lit_c3", int'(fir_c3), 4);

        drive(1, 1, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        repeat (5) drive(1, 3, 0, 0, 0, 0);

        // Mid-stream commit of {-1,0,0,0} while samples keep arriving.
        drive(1, 3, 1, 0, -1, 0);
        drive(1, 3, 1, 1, 0, 0);
        drive(1, 3, 1, 2, 0, 0);
        drive(1, 3, 1, 3, 0, 1);
        s_valid = 1'b1;
        s_data  = 7'sd3;
        cfg_wr  = 1'b0;
        cfg_commit = 1'b0;
        wait_commit_end("lit_commit2");
        chk("lit_neg_c0", int'(fir_c0), -1);
        drive(1, 3, 0, 0, 0, 0);
        chk("lit_accept_after", int'(y_valid), 1);

        drive(0, 0, 1, 0, 2, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, (i < 4) ? 1'b1 : 1'b0);
            pulses += int'(commit_done);
        end
        chk("lit_held_commit_pulses", pulses, 1);
        chk("lit_held_c0", int'(fir_c0), 2);

        drive(0, 0, 1, 0, 5, 1);
        idle();
        idle();
        idle();
        drive(0, 0, 1, 0, 7, 0);
        chk("lit_swapwr_c0", int'(fir_c0), 5);
`ifdef FIR4_COEF_SCHED_RDBK_EN
        rd_sel = 1'b0;
        rd_addr = 2'd0;
        #1;
        chk("lit_swapwr_shadow", int'(rd_data), 7);
`endif
        idle();
        drive(0, 0, 0, 0, 0, 1);
        wait_commit_end("lit_commit3");
        chk("lit_swapwr_c0_next", int'(fir_c0), 7);

        drive(0, 0, 0, 0, 0, 1);
        idle();
        rstn = 1'b0;
        #1;
        chk("lit_rst_drain_busy", int'(cfg_busy), 0);
        chk("lit_rst_drain_c0", int'(fir_c0), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            pulses += int'(commit_done);
        end
        chk("lit_rst_drain_pulses", pulses, 0);
        chk("lit_rst_drain_ready", int'(s_ready), 1);

        for (int i = 0; i < 3000; i++) begin
            v = int'($urandom);
`ifdef FIR4_COEF_SCHED_RDBK_EN
            rd_sel  = v[20];
            rd_addr = v[22:21];
`endif
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                idle();
                rstn = 1'b1;
            end else begin
                drive(v[0] | v[1], int'($urandom), v[3:2] == 2'b00, int'(v[5:4]), int'($urandom),
                      v[9:6] == 4'b0000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
